// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requesting datapath and the bit-serial adder controller.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;

   // Requester side: issues operations, observes status and result.
   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, overflow
   );

   // Controller side.
   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, overflow
   );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: drives one full-adder slice over WIDTH cycles, LSB first,
// keeping the carry in a register and assembling the result in a right-shifting register.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   serial_add_ctrl_if.slave bus
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             sum_bit;
   logic             carry_out;
   logic             last_bit;

   // Full-adder slice on the current LSBs.
   assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

   // Next-state: load on accepted start, shift one bit per RUN cycle, latch flags on the last bit.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               // Subtraction is a + ~b + 1: invert b and use carry-in of 1.
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
               cnt_d   = '0;
               res_d   = '0;
               state_d = StRun;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = carry_out;
            cnt_d   = cnt_q + CntW'(1);
            if (last_bit) begin
               // carry_q is the carry into the MSB at this point.
               cout_d  = carry_out;
               ovf_d   = carry_out ^ carry_q;
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy     = (state_q == StRun);
   assign bus.done     = (state_q == StDone);
   assign bus.result   = res_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller that sequences a single full-adder bit slice over WIDTH cycles.
- It loads two operands and shifts them LSB-first through the slice, holding the carry in a register between cycles.
- It assembles the result and reports completion through a start/busy/done handshake.
- It sits between a requesting datapath and the existing full-adder cell, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk       input   1      rising-edge clock
rst       input   1      synchronous reset, active-high
start     input   1      request pulse; sampled only when accepting (IDLE or DONE)
sub       input   1      0 = a+b, 1 = a-b; sampled with start
a         input   WIDTH  operand A, sampled with start
b         input   WIDTH  operand B, sampled with start
busy      output  1      high while state = RUN
done      output  1      one-cycle pulse, high while state = DONE
result    output  WIDTH  sum/difference; valid from done, held until next accepted start
cout      output  1      final carry out (for sub: 1 = no borrow)
overflow  output  1      signed overflow = carry into MSB XOR cout

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state=IDLE; busy, done, result, cout, overflow, count and carry all 0. rst has priority over every other input on any cycle.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge: load A_sh=a and B_sh=(sub ? ~b : b); carry=sub; count=0; result shift reg=0; go to RUN.
- IDLE, start=0: remain IDLE.
- RUN, each edge:
  - The slice computes s = A_sh[0]^B_sh[0]^carry and c = majority(A_sh[0], B_sh[0], carry).
  - result shifts right with s entering the MSB.
  - A_sh and B_sh shift right by 1; carry=c; count++.
  - At the edge where count = WIDTH-1 (last bit), latch cout=c and overflow=c XOR carry (carry here is the carry into the MSB), then go to DONE.
- DONE: done=1 for exactly one cycle; result, cout and overflow are stable. Next edge goes to IDLE, or, if start=1, reloads and goes directly to RUN (back-to-back accepted).
- Latency: start accepted at edge E0. busy=1 after E0 through edge E0+WIDTH. done=1 in the cycle after edge E0+WIDTH. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- start while in RUN is ignored; it causes no queuing and no restart.
- a, b and sub are don't-care except at the accepting edge; changing them during RUN has no effect.
- result, cout and overflow hold their last values through IDLE until the next accepted start, which clears result to 0 at the load edge. cout and overflow keep their old values until the final-bit edge.
- Reset mid-RUN: abort immediately to the reset state; no done pulse is generated.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1 via carry-in=1. Signed overflow follows two's-complement rules for both add and sub.
- busy and done are never high at the same time.
- Implementation: one combinational full-adder slice, a $clog2(WIDTH)-bit counter, and the shift/carry registers. No multi-bit adder may be used.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, sub=0, start pulse -> busy for 8 cycles; done in 9th cycle; result=0x7F, cout=0, overflow=0.
- a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 -> result=0x80, cout=0, overflow=1.
- sub=1, a=0x10, b=0x20 -> result=0xF0, cout=0 (borrow), overflow=0. Then sub=1, a=0x80, b=0x01 -> result=0x7F, cout=1, overflow=1.
- start re-asserted with different operands at cycle 3 of RUN -> ignored; original result delivered at the same latency. start held high in the DONE cycle -> new op accepted, busy reasserts the next cycle, no IDLE cycle.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, result=0, cout=0, overflow=0, state IDLE. A following start completes correctly with full latency.
- Random sweep of 1000 ops at WIDTH=8 and WIDTH=13 (add and sub mixed) against a reference model -> result, cout and overflow match; done count equals accepted-start count.
